// File: rtl/regfile_mp_if.sv
// Register-file port bundle: clear handshake, NW write ports and NR read ports, packed per port.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int NR    = 2,
    parameter int NW    = 1
);
    localparam int AW = $clog2(DEPTH);

    logic                 clr_req;
    logic                 clr_busy;
    logic [NW-1:0]        wb_en;
    logic [NW*AW-1:0]     rd_index;
    logic [NW*XLEN-1:0]   wb_data;
    logic [NR*AW-1:0]     rs_index;
    logic [NR*XLEN-1:0]   rs_data_out;

    modport master (
        output clr_req, wb_en, rd_index, wb_data, rs_index,
        input  clr_busy, rs_data_out
    );

    modport slave (
        input  clr_req, wb_en, rd_index, wb_data, rs_index,
        output clr_busy, rs_data_out
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with NR combinational reads, NW clocked writes and a post-reset clear sweep.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  rf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            clr_busy_q, clr_busy_d;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];

    logic [NW-1:0]   wr_vld;
    logic [AW-1:0]   wr_idx [NW];
    logic [XLEN-1:0] wr_dat [NW];
    logic [AW-1:0]   rs_idx [NR];
    logic [XLEN-1:0] rs_dat [NR];

    function automatic logic in_range(input logic [AW-1:0] idx);
        return {1'b0, idx} < DEPTH_W;
    endfunction

    function automatic logic zero_hit(input logic [AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // Clear sequencer next-state
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_busy_d = clr_busy_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == LAST) begin
                    state_d    = IDLE;
                    clr_cnt_d  = '0;
                    clr_busy_d = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (rf.clr_req) begin
                    state_d    = CLEAR;
                    clr_cnt_d  = '0;
                    clr_busy_d = 1'b1;
                end
            end
            default: begin
                state_d    = CLEAR;
                clr_cnt_d  = '0;
                clr_busy_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    // A write survives only in IDLE, in range, and not aimed at a hardwired zero
    always_comb begin
        wr_vld = '0;
        for (int k = 0; k < NW; k++) begin
            wr_idx[k] = rf.rd_index[k*AW +: AW];
            wr_dat[k] = rf.wb_data[k*XLEN +: XLEN];
            wr_vld[k] = rf.wb_en[k] && (state_q == IDLE) &&
                        in_range(wr_idx[k]) && !zero_hit(wr_idx[k]);
        end
    end

    // Ascending port order lets the highest-numbered port win a conflict
    always_comb begin
        mem_d = mem_q;
        if (state_q == CLEAR) begin
            mem_d[clr_cnt_q] = '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (wr_vld[k]) begin
                    mem_d[wr_idx[k]] = wr_dat[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rf.rs_data_out = '0;
        for (int j = 0; j < NR; j++) begin
            rs_idx[j] = rf.rs_index[j*AW +: AW];
            rs_dat[j] = '0;
            if (!clr_busy_q && in_range(rs_idx[j]) && !zero_hit(rs_idx[j])) begin
                rs_dat[j] = mem_q[rs_idx[j]];
                if (BYPASS) begin
                    for (int k = 0; k < NW; k++) begin
                        if (wr_vld[k] && (wr_idx[k] == rs_idx[j])) begin
                            rs_dat[j] = wr_dat[k];
                        end
                    end
                end
            end
            rf.rs_data_out[j*XLEN +: XLEN] = rs_dat[j];
        end
    end

    assign rf.clr_busy = clr_busy_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, the next generation of the core's single-write/dual-read register file. It provides NR combinational read ports and NW clocked write ports. An optional hardwired-zero register 0 is supported. A built-in clear sequencer zeroes every entry after reset or on request, so no flop-array async reset is needed. It sits between decode (read ports) and writeback (write ports) in the pipeline.

Parameters:
XLEN, 32, data width of each register in bits
DEPTH, 32, number of registers; need not be a power of two (minimum 2)
NR, 2, number of read ports
NW, 1, number of write ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary
AW (localparam), $clog2(DEPTH), index width

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
clr_req  input  1  pulse high to request a full clear (sampled only in IDLE)
clr_busy  output  1  high while the clear sequencer runs
wb_en  input  NW  per-port write enable
rd_index  input  NW*AW  write index; port k occupies bits [k*AW +: AW]
wb_data  input  NW*XLEN  write data; port k occupies bits [k*XLEN +: XLEN]
rs_index  input  NR*AW  read index; port j occupies bits [j*AW +: AW]
rs_data_out  output  NR*XLEN  read data; port j occupies bits [j*XLEN +: XLEN]

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Clear FSM states: CLEAR and IDLE. An internal counter clr_cnt is AW bits wide.
- While rst is high: state = CLEAR, clr_cnt = 0, clr_busy = 1, all rs_data_out = 0. The array contents themselves are not reset.
- In CLEAR, on each clk edge: write 0 to entry clr_cnt and increment clr_cnt.
  - When clr_cnt == DEPTH-1 is written, move to IDLE.
  - The sweep therefore takes exactly DEPTH cycles after rst falls.
  - clr_busy drops in the first IDLE cycle.
- In IDLE, clr_req = 1 on an edge sets state = CLEAR and clr_cnt = 0. clr_busy rises the next cycle.
- clr_req while in CLEAR is ignored. The sweep is not restarted.
- rst asserted mid-sweep restarts the sequence from clr_cnt = 0.
- While clr_busy = 1:
  - all wb_en are ignored; nothing from the write ports is written;
  - all rs_data_out = 0.
- Reads (IDLE):
  - combinational, zero latency: rs_data_out[j] = array[rs_index[j]];
  - a write on edge N is visible on reads from edge N onward (the cycle after it was presented).
- Writes (IDLE): on a rising edge, port k writes wb_data[k] to array[rd_index[k]] when wb_en[k] = 1.
- Write conflict: when several enabled ports target the same index in one cycle, the highest-numbered port wins.
- ZERO_REG = 1:
  - writes to index 0 are dropped;
  - reads of index 0 return 0 regardless of array contents;
  - the clear sweep still writes entry 0.
- Out-of-range index (index >= DEPTH, possible only when DEPTH is not a power of two):
  - the write is dropped;
  - the read returns 0.
- No X propagation: every read path is defined for every index and every state.

Optional Feature:
RF_BYPASS_EN:
- Defined: in IDLE, a read port whose rs_index matches the rd_index of an enabled, non-dropped write in the same cycle returns that cycle's wb_data instead of the array value.
  - When several write ports match, the highest-numbered port wins, consistent with the write-conflict rule.
  - Index 0 with ZERO_REG = 1 still reads 0.
- Undefined: reads return array contents only; same-cycle write data is visible the following cycle.

Test Plan:
- Reset sweep: hold rst 3 cycles, release -> clr_busy = 1 for exactly 32 cycles, then 0; all 32 entries read 0.
- Basic write/read: write 0xDEADBEEF to reg 5 -> rs_data_out[0] = 0xDEADBEEF with rs_index = 5 from the next cycle; reg 6 still reads 0.
- Zero register: write 0x12345678 to reg 0 with ZERO_REG = 1 -> reads 0. With ZERO_REG = 0 -> reads 0x12345678.
- Conflict: NW = 2, both ports write reg 7 (port0 0x11, port1 0x22) in one cycle -> reg 7 = 0x22.
- Clear/busy: fill regs 1..31, pulse clr_req, attempt a write to reg 3 during the sweep -> write dropped; reads 0 during the sweep and after it completes. A second clr_req mid-sweep leaves the duration at 32 cycles.
- Bypass (RF_BYPASS_EN defined): write 0xA5A5A5A5 to reg 9 while reading reg 9 in the same cycle -> 0xA5A5A5A5 is returned that cycle. Without the macro, the old value (0) is returned that cycle.
